// File: rtl/mis_stim_gen.sv
// mis_stim_gen -- stimulus and capture for one NOR2 multiple-input-switching
// delay chain.
//
// A run starts with both chain inputs (A, B) at the opposite of the launch
// level. They stay there for a settle period. Then one input makes the lead
// edge and the other makes the trail edge, a programmable number of cycles
// later. Both edges go in the same direction. Latency is counted from the
// cycle the lead edge appears on the outputs. Counting stops when the
// resynchronised chain output leaves the level it had at the end of settle.
//
// Ports
//   clk_i          clock, all logic on the rising edge
//   rst_i          synchronous reset, active-high; aborts a run with no done
//   start_i        1-cycle run request, sampled only while idle
//   cfg_rise_i     1: edges 0->1, 0: edges 1->0            (latched on start)
//   cfg_b_first_i  1: B leads and A trails, 0: A leads     (latched on start)
//   cfg_skew_i     cycles from lead to trail edge, 0 = same cycle (latched)
//   to_a_o/to_b_o  registered drives to chain inputs A and B
//   dut_out_i      chain output, asynchronous to clk_i
//   busy_o         high from the accepted start through the done cycle
//   done_o         1-cycle pulse at the end of a run
//   timeout_o      valid with done_o: no response before the counter saturated
//   lat_o          response latency in cycles; changes only when done_o rises
module mis_stim_gen #(
  parameter int SKEW_W = 8,
  parameter int TMO_W  = 12,
  parameter int SETTLE = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cfg_rise_i,
  input  logic              cfg_b_first_i,
  input  logic [SKEW_W-1:0] cfg_skew_i,
  output logic              to_a_o,
  output logic              to_b_o,
  input  logic              dut_out_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [TMO_W-1:0]  lat_o
);

  localparam int                SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [TMO_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_LAUNCH, S_WAIT_SKEW, S_WAIT_RESP, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                rise_q, rise_d;
  logic                bfirst_q, bfirst_d;
  logic [SKEW_W-1:0]   skew_q, skew_d;
  logic                to_a_q, to_a_d;
  logic                to_b_q, to_b_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;
  logic [TMO_W-1:0]    lat_q, lat_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic [TMO_W-1:0]    hit_q, hit_d;     // latency of a response seen before the trail edge
  logic                got_q, got_d;
  logic [SKEW_W-1:0]   sk_q, sk_d;       // separate skew counter so cnt_q may saturate
  logic [SET_W-1:0]    set_q, set_d;
  logic                ref_q, ref_d;     // settled chain output level before launch
  logic                s1_q, s2_q;       // two-flop synchroniser for dut_out_i

  logic                launch_lead;
  logic                launch_trail;
  logic                resp;
  logic [TMO_W-1:0]    cnt_inc;

  assign resp    = (s2_q != ref_q);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TMO_W'(1);

  // NOTE: the synchroniser flops get reset along with everything else. This
  // keeps the first settle reference deterministic.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= dut_out_i;
      s2_q <= s1_q;
    end
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch and
  // takes priority over every next-state value, start_i included.
  // All state updates are non-blocking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      rise_q    <= 1'b0;
      bfirst_q  <= 1'b0;
      skew_q    <= '0;
      to_a_q    <= 1'b0;
      to_b_q    <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      lat_q     <= '0;
      cnt_q     <= '0;
      hit_q     <= '0;
      got_q     <= 1'b0;
      sk_q      <= '0;
      set_q     <= '0;
      ref_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rise_q    <= rise_d;
      bfirst_q  <= bfirst_d;
      skew_q    <= skew_d;
      to_a_q    <= to_a_d;
      to_b_q    <= to_b_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      lat_q     <= lat_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      got_q     <= got_d;
      sk_q      <= sk_d;
      set_q     <= set_d;
      ref_q     <= ref_d;
    end
  end

  // NOTE: every variable gets a hold/default value first, so no path can
  // infer a latch. Blocking assignments are used here, so a later line can
  // read a value written earlier in the same pass (got_d, hit_d).
  always_comb begin
    state_d      = state_q;
    rise_d       = rise_q;
    bfirst_d     = bfirst_q;
    skew_d       = skew_q;
    to_a_d       = to_a_q;
    to_b_d       = to_b_q;
    busy_d       = busy_q;
    timeout_d    = timeout_q;
    lat_d        = lat_q;
    cnt_d        = cnt_q;
    hit_d        = hit_q;
    got_d        = got_q;
    sk_d         = sk_q;
    set_d        = set_q;
    ref_d        = ref_q;
    launch_lead  = 1'b0;
    launch_trail = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          rise_d    = cfg_rise_i;
          bfirst_d  = cfg_b_first_i;
          skew_d    = cfg_skew_i;
          busy_d    = 1'b1;
          timeout_d = 1'b0;
          to_a_d    = ~cfg_rise_i;
          to_b_d    = ~cfg_rise_i;
          set_d     = '0;
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        set_d = set_q + SET_W'(1);
        if (set_q == SET_LAST) begin
          ref_d   = s2_q;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        launch_lead = 1'b1;
        cnt_d       = '0;
        got_d       = 1'b0;
        sk_d        = '0;
        if (skew_q == '0) begin
          launch_trail = 1'b1;
          state_d      = S_WAIT_RESP;
        end else begin
          state_d      = S_WAIT_SKEW;
        end
      end
      S_WAIT_SKEW: begin
        cnt_d = cnt_inc;
        sk_d  = sk_q + SKEW_W'(1);
        if (resp && !got_q) begin
          hit_d = cnt_q;
          got_d = 1'b1;
        end
        // Register the trail drive one cycle early so the edge lands exactly
        // skew cycles after the lead edge.
        if (sk_q == skew_q - SKEW_W'(1)) begin
          launch_trail = 1'b1;
          if (got_d) begin
            lat_d   = hit_d;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_RESP;
          end
        end
      end
      S_WAIT_RESP: begin
        cnt_d = cnt_inc;
        if (resp) begin
          lat_d   = cnt_q;
          state_d = S_DONE;
        end else if (cnt_q == CNT_MAX) begin
          lat_d     = CNT_MAX;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (launch_lead) begin
      if (bfirst_q) to_b_d = rise_q;
      else          to_a_d = rise_q;
    end
    if (launch_trail) begin
      if (bfirst_q) to_a_d = rise_q;
      else          to_b_d = rise_q;
    end
  end

  assign to_a_o    = to_a_q;
  assign to_b_o    = to_b_q;
  assign busy_o    = busy_q;
  assign done_o    = (state_q == S_DONE);
  assign timeout_o = timeout_q;
  assign lat_o     = lat_q;

endmodule

// File: tb/tb_mis_stim_gen.sv
// tb_mis_stim_gen -- self-checking bench for mis_stim_gen.
// The chain is modelled as a delayed copy of A or B, or as a constant 0.
// Expected latency, run length and timeout are computed from the edge
// offsets with plain arithmetic.
module tb_mis_stim_gen;

  localparam int SKEW_W = 8;
  localparam int TMO_W  = 6;
  localparam int SETTLE = 16;
  localparam int MAXC   = (1 << TMO_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              cfg_rise = 1'b0;
  logic              cfg_b_first = 1'b0;
  logic [SKEW_W-1:0] cfg_skew = '0;
  logic              to_a, to_b;
  logic              dut_out = 1'b0;
  logic              busy, done, timeout;
  logic [TMO_W-1:0]  lat;

  mis_stim_gen #(.SKEW_W(SKEW_W), .TMO_W(TMO_W), .SETTLE(SETTLE)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .cfg_rise_i   (cfg_rise),
    .cfg_b_first_i(cfg_b_first),
    .cfg_skew_i   (cfg_skew),
    .to_a_o       (to_a),
    .to_b_o       (to_b),
    .dut_out_i    (dut_out),
    .busy_o       (busy),
    .done_o       (done),
    .timeout_o    (timeout),
    .lat_o        (lat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int prev_lat = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Chain model: 0 = constant low, 1 = to_a delayed, 2 = to_b delayed.
  int          src_sel = 0;
  int          dly     = 0;
  logic [15:0] hist    = '0;
  always @(negedge clk) begin
    logic v;
    v       = (src_sel == 2) ? to_b : to_a;
    hist    = {hist[14:0], v};
    dut_out = (src_sel == 0) ? 1'b0 : hist[dly];
  end

  // Outcome of one run, measured from the lead edge.
  function automatic void model(input bit bfirst, input int skew, input int sel, input int d,
                                output int e_lat, output bit e_tmo, output int e_done);
    int off, resp;
    bit src_is_lead;
    src_is_lead = (sel == 1) ? !bfirst : bfirst;
    off  = src_is_lead ? 0 : skew;
    resp = off + d + 2;
    if (sel != 0 && skew > 0 && resp <= skew - 1) begin
      e_lat  = (resp > MAXC) ? MAXC : resp;
      e_tmo  = 1'b0;
      e_done = skew;
    end else if (sel != 0 && resp <= MAXC) begin
      e_lat  = resp;
      e_tmo  = 1'b0;
      e_done = resp + 1;
    end else begin
      e_lat  = MAXC;
      e_tmo  = 1'b1;
      e_done = ((skew > MAXC) ? skew : MAXC) + 1;
    end
  endfunction

  task automatic run_case(input bit rise, input bit bfirst, input int skew,
                          input int sel, input int d, input bit disturb);
    int tl, tt, td, cyc, e_lat, e_done;
    bit e_tmo, lead_v, trail_v, lat_early, busy_in_done;
    logic [TMO_W-1:0] lat_at_done;
    logic tmo_at_done;
    @(negedge clk);
    src_sel     = sel;
    dly         = d;
    cfg_rise    = rise;
    cfg_b_first = bfirst;
    cfg_skew    = SKEW_W'(skew);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_on", 32'(busy), 1);
    check("tmo_clr", 32'(timeout), 0);
    check("settle_lvl", 32'({to_a, to_b}), 32'({~rise, ~rise}));
    tl = -1; tt = -1; td = -1; cyc = 1; lat_early = 0;
    busy_in_done = 0; lat_at_done = '0; tmo_at_done = 1'b0;
    while (td < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      lead_v  = bfirst ? to_b : to_a;
      trail_v = bfirst ? to_a : to_b;
      if (tl < 0 && lead_v == rise) tl = cyc;
      if (tt < 0 && trail_v == rise) tt = cyc;
      if (done) begin
        td = cyc; busy_in_done = busy; lat_at_done = lat; tmo_at_done = timeout;
      end else if (32'(lat) != prev_lat) begin
        lat_early = 1;
      end
      if (disturb && tl > 0 && cyc == tl + 2) begin
        start    = 1'b1;
        cfg_skew = SKEW_W'(skew + 7);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (td < 0) begin
      check("done_seen", 0, 1);
    end else begin
      model(bfirst, skew, sel, d, e_lat, e_tmo, e_done);
      check("settle_hold", 32'(tl - 1 >= SETTLE), 1);
      check("skew", 32'(tt - tl), 32'(skew));
      check("done_off", 32'(td - tl), 32'(e_done));
      check("lat", 32'(lat_at_done), 32'(e_lat));
      check("timeout", 32'(tmo_at_done), 32'(e_tmo));
      check("busy_in_done", 32'(busy_in_done), 1);
      check("lat_held", 32'(lat_early), 0);
      @(negedge clk);
      check("done_pulse", 32'(done), 0);
      check("busy_off", 32'(busy), 0);
      check("final_lvl", 32'({to_a, to_b}), 32'({rise, rise}));
      check("lat_hold_after", 32'(lat), 32'(e_lat));
      if (disturb) begin
        repeat (4) @(negedge clk);
        check("no_queue", 32'(busy), 0);
      end
      prev_lat = e_lat;
    end
  endtask

  initial begin
    bit saw_done;
    repeat (3) @(negedge clk);
    check("rst_outs", 32'({to_a, to_b, busy, done, timeout}), 0);
    check("rst_lat", 32'(lat), 0);
    rst = 1'b0;

    // Directed cases.
    run_case(1'b1, 1'b0, 0, 1, 0, 1'b0);     // loopback A, same-cycle edges: lat 2
    run_case(1'b1, 1'b0, 3, 2, 5, 1'b0);     // B delayed 5, skew 3: lat 10
    run_case(1'b0, 1'b0, 5, 0, 0, 1'b0);     // no response, falling edges: timeout
    run_case(1'b1, 1'b1, 20, 1, 0, 1'b0);    // B first, A loopback: lat 22
    run_case(1'b1, 1'b1, 20, 2, 0, 1'b0);    // response before trail: ends at trail
    run_case(1'b1, 1'b0, 100, 0, 0, 1'b0);   // skew beyond counter range, no response
    run_case(1'b0, 1'b0, 100, 1, 0, 1'b0);   // skew beyond counter range, early response
    run_case(1'b1, 1'b0, MAXC, 0, 0, 1'b0);  // skew equal to counter maximum
    run_case(1'b1, 1'b0, 12, 1, 3, 1'b1);    // start and skew change mid-run ignored

    // Reset in the middle of the skew wait.
    @(negedge clk);
    src_sel = 1; dly = 0; cfg_rise = 1'b1; cfg_b_first = 1'b0; cfg_skew = 8'd30; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (SETTLE + 6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outs", 32'({to_a, to_b, busy, done, timeout}), 0);
    check("abort_lat", 32'(lat), 0);
    saw_done = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 0);
    prev_lat = 0;
    run_case(1'b1, 1'b0, 4, 1, 1, 1'b0);

    // start together with reset is dropped.
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_in_rst", 32'(busy), 0);
    prev_lat = 0;

    // Randomised runs.
    for (int i = 0; i < 16; i++) begin
      run_case(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 30)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 8)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
